// File: rtl/chamber_timer.sv
// Fill/drain/wait duration timer: *Finished rises DUR*TICK_DIV edges after the request is sampled; every output is registered.
// Level requests with no backpressure; define CHAMBER_TIMER_FAULT_EN to trap conflicting requests in a FAULT state.
module chamber_timer #(
  parameter int TICK_DIV  = 50000000,
  parameter int FILL_SEC  = 7,
  parameter int DRAIN_SEC = 8,
  parameter int WAIT_SEC  = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             filling,
  input  logic             draining,
  input  logic             waiting,
  output logic             fillFinished,
  output logic             drainFinished,
  output logic             waitFinished,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] secLeft
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] FILL_DUR  = (FILL_SEC  == 0) ? CNT_W'(1) : CNT_W'(FILL_SEC);
  localparam logic [CNT_W-1:0] DRAIN_DUR = (DRAIN_SEC == 0) ? CNT_W'(1) : CNT_W'(DRAIN_SEC);
  localparam logic [CNT_W-1:0] WAIT_DUR  = (WAIT_SEC  == 0) ? CNT_W'(1) : CNT_W'(WAIT_SEC);

`ifdef CHAMBER_TIMER_FAULT_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  typedef enum logic [1:0] {KIND_FILL, KIND_DRAIN, KIND_WAIT} kind_t;

  state_t          state, stateNext;
  kind_t           kind, kindNext;
  logic [PW-1:0]   presc, prescNext;
  logic [CNT_W-1:0] secNext;
  logic [2:0]      finNext;
  logic            busyNext;
  logic            activeReq;

  function automatic logic [CNT_W-1:0] durOf(input kind_t k);
    case (k)
      KIND_DRAIN: durOf = DRAIN_DUR;
      KIND_WAIT:  durOf = WAIT_DUR;
      default:    durOf = FILL_DUR;
    endcase
  endfunction

  always_comb begin
    case (kind)
      KIND_DRAIN: activeReq = draining;
      KIND_WAIT:  activeReq = waiting;
      default:    activeReq = filling;
    endcase
  end

`ifdef CHAMBER_TIMER_FAULT_EN
  logic [1:0] reqCount;
  logic       otherReq;
  logic       faultNext;
  assign reqCount = 2'(filling) + 2'(draining) + 2'(waiting);
  // With the active request high, any second high request is a conflict.
  assign otherReq = (reqCount > 2'd1);
`endif

  always_comb begin
    stateNext = state;
    kindNext  = kind;
    prescNext = presc;
    secNext   = secLeft;
    case (state)
      IDLE: begin
        prescNext = '0;
        secNext   = '0;
`ifdef CHAMBER_TIMER_FAULT_EN
        if (reqCount > 2'd1) begin
          stateNext = FAULT;
        end else if (reqCount == 2'd1) begin
          stateNext = RUN;
          kindNext  = draining ? KIND_DRAIN : (filling ? KIND_FILL : KIND_WAIT);
          secNext   = durOf(kindNext);
        end
`else
        if (draining || filling || waiting) begin
          stateNext = RUN;
          kindNext  = draining ? KIND_DRAIN : (filling ? KIND_FILL : KIND_WAIT);
          secNext   = durOf(kindNext);
        end
`endif
      end
      RUN: begin
        if (!activeReq) begin
          stateNext = IDLE;
          prescNext = '0;
          secNext   = '0;
`ifdef CHAMBER_TIMER_FAULT_EN
        end else if (otherReq) begin
          stateNext = FAULT;
          prescNext = '0;
          secNext   = '0;
`endif
        end else if (presc == PRESC_MAX) begin
          prescNext = '0;
          if (secLeft <= CNT_W'(1)) begin
            stateNext = DONE;
            secNext   = '0;
          end else begin
            secNext = secLeft - CNT_W'(1);
          end
        end else begin
          prescNext = presc + PW'(1);
        end
      end
      DONE: begin
        if (!activeReq) begin
          stateNext = IDLE;
`ifdef CHAMBER_TIMER_FAULT_EN
        end else if (otherReq) begin
          stateNext = FAULT;
`endif
        end
      end
`ifdef CHAMBER_TIMER_FAULT_EN
      FAULT: begin
        prescNext = '0;
        secNext   = '0;
        if (reqCount == 2'd0) stateNext = IDLE;
      end
`endif
      default: begin
        stateNext = IDLE;
        prescNext = '0;
        secNext   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they leave a flop.
    finNext = 3'b000;
    if (stateNext == DONE) begin
      case (kindNext)
        KIND_DRAIN: finNext = 3'b010;
        KIND_WAIT:  finNext = 3'b100;
        default:    finNext = 3'b001;
      endcase
    end
    busyNext = (stateNext == RUN) || (stateNext == DONE);
`ifdef CHAMBER_TIMER_FAULT_EN
    faultNext = (stateNext == FAULT);
`endif
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state         <= IDLE;
      kind          <= KIND_FILL;
      presc         <= '0;
      secLeft       <= '0;
      fillFinished  <= 1'b0;
      drainFinished <= 1'b0;
      waitFinished  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= stateNext;
      kind          <= kindNext;
      presc         <= prescNext;
      secLeft       <= secNext;
      fillFinished  <= finNext[0];
      drainFinished <= finNext[1];
      waitFinished  <= finNext[2];
      busy          <= busyNext;
    end
  end

`ifdef CHAMBER_TIMER_FAULT_EN
  always_ff @(posedge clk) begin
    if (nReset) fault <= 1'b0;
    else        fault <= faultNext;
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_chamber_timer.sv
// Bench for chamber_timer: elapsed-time reference model checked every cycle, directed scenarios, random requests.
module tb_chamber_timer;
  localparam int TD = 4;
  localparam int FS = 3;
  localparam int DS = 2;
  localparam int WS = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          nReset = 1'b1;
  logic          filling = 1'b0;
  logic          draining = 1'b0;
  logic          waiting = 1'b0;
  logic          fillFinished, drainFinished, waitFinished, busy, fault;
  logic [CW-1:0] secLeft;

  chamber_timer #(.TICK_DIV(TD), .FILL_SEC(FS), .DRAIN_SEC(DS), .WAIT_SEC(WS), .CNT_W(CW)) dut (
    .clk(clk), .nReset(nReset),
    .filling(filling), .draining(draining), .waiting(waiting),
    .fillFinished(fillFinished), .drainFinished(drainFinished), .waitFinished(waitFinished),
    .busy(busy), .fault(fault), .secLeft(secLeft)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 timing, 2 fault; outputs derived from elapsed edges.
  int       mMode = 0;
  int       mAct = 0;
  int       mStart = 0;
  int       cyc = 0;
  int       mSec = 0;
  int       nReq, el;
  bit [2:0] mFin;
  bit [2:0] r;
  bit       mBusy, mFault;

  function automatic int durOf(input int a);
    int d;
    d = (a == 1) ? DS : ((a == 2) ? WS : FS);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk) begin
    r    = {waiting, draining, filling};
    nReq = int'(r[0]) + int'(r[1]) + int'(r[2]);
    cyc++;
    if (nReset) begin
      mMode = 0;
    end else begin
      case (mMode)
        0: begin
`ifdef CHAMBER_TIMER_FAULT_EN
          if (nReq >= 2) mMode = 2;
          else if (nReq == 1) begin
            mMode = 1; mAct = r[0] ? 0 : (r[1] ? 1 : 2); mStart = cyc;
          end
`else
          if (nReq >= 1) begin
            mMode = 1; mAct = r[1] ? 1 : (r[0] ? 0 : 2); mStart = cyc;
          end
`endif
        end
        1: begin
          if (!r[mAct]) mMode = 0;
`ifdef CHAMBER_TIMER_FAULT_EN
          else if (nReq > 1) mMode = 2;
`endif
        end
        default: if (nReq == 0) mMode = 0;
      endcase
    end
    mFin   = 3'b000;
    mSec   = 0;
    mBusy  = (mMode == 1);
    mFault = (mMode == 2);
    if (mMode == 1) begin
      el = cyc - mStart;
      if (el >= durOf(mAct) * TD) mFin[mAct] = 1'b1;
      else mSec = durOf(mAct) - el / TD;
    end
    #1;
    chk("cycle_outputs",
        int'({fillFinished, drainFinished, waitFinished, busy, fault, secLeft}),
        int'({mFin[0], mFin[1], mFin[2], mBusy, mFault, 8'(mSec)}));
  end

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    edges(2);
    chk("reset_secLeft", int'(secLeft), 0);
    chk("reset_flags", int'({fillFinished, drainFinished, waitFinished, busy, fault}), 0);
    nReset = 1'b0;
    edges(1);

    // Fill: edges are numbered from the edge that samples filling high.
    filling = 1'b1;
    edges(1);
    chk("fill_sec_e0", int'(secLeft), 3);
    chk("model_sec_e0", mSec, 3);
    chk("fill_busy_e0", int'(busy), 1);
    edges(3);  chk("fill_sec_e3", int'(secLeft), 3);
    edges(1);  chk("fill_sec_e4", int'(secLeft), 2);
    edges(4);  chk("fill_sec_e8", int'(secLeft), 1);
    edges(3);  chk("fill_fin_e11", int'(fillFinished), 0);
    edges(1);  chk("fill_fin_e12", int'(fillFinished), 1);
    chk("fill_sec_e12", int'(secLeft), 0);
    chk("model_fin_e12", int'(mFin[0]), 1);
    edges(2);
    filling = 1'b0;
    edges(1);
    chk("fill_fin_e15", int'(fillFinished), 0);
    chk("fill_busy_e15", int'(busy), 0);

    // Wait then drain.
    waiting = 1'b1;
    edges(1);  chk("wait_sec_e0", int'(secLeft), 5);
    edges(19); chk("wait_fin_e19", int'(waitFinished), 0);
    edges(1);  chk("wait_fin_e20", int'(waitFinished), 1);
    edges(1);
    waiting = 1'b0;
    edges(1);  chk("wait_fin_e22", int'(waitFinished), 0);
    draining = 1'b1;
    edges(1);  chk("drain_sec_e23", int'(secLeft), 2);
    edges(7);  chk("drain_fin_e30", int'(drainFinished), 0);
    edges(1);  chk("drain_fin_e31", int'(drainFinished), 1);
    draining = 1'b0;
    edges(1);

    // Abort.
    draining = 1'b1;
    edges(6);  chk("abort_sec_e5", int'(secLeft), 1);
    draining = 1'b0;
    edges(1);
    chk("abort_sec_e6", int'(secLeft), 0);
    chk("abort_busy_e6", int'(busy), 0);
    edges(8);  chk("abort_nofin", int'(drainFinished), 0);

    // Reset mid-count.
    filling = 1'b1;
    edges(6);
    nReset = 1'b1;
    edges(1);
    chk("rst_outputs_e6", int'({fillFinished, drainFinished, waitFinished, busy, fault, secLeft}), 0);
    nReset = 1'b0;
    edges(1);  chk("rst_sec_e7", int'(secLeft), 3);
    edges(11); chk("rst_fin_e18", int'(fillFinished), 0);
    edges(1);  chk("rst_fin_e19", int'(fillFinished), 1);
    filling = 1'b0;
    edges(1);

    // Simultaneous requests.
    filling = 1'b1;
    draining = 1'b1;
    edges(1);
`ifdef CHAMBER_TIMER_FAULT_EN
    chk("conf_fault_e0", int'(fault), 1);
    chk("conf_busy_e0", int'(busy), 0);
    edges(4);
    chk("conf_fin_e4", int'({fillFinished, drainFinished, waitFinished}), 0);
    filling = 1'b0;
    draining = 1'b0;
    edges(1);
    chk("conf_fault_e5", int'(fault), 0);
`else
    chk("conf_sec_e0", int'(secLeft), 2);
    chk("conf_fault_e0", int'(fault), 0);
    edges(7);  chk("conf_fin_e7", int'(drainFinished), 0);
    edges(1);
    chk("conf_fin_e8", int'(drainFinished), 1);
    chk("conf_fill_e8", int'(fillFinished), 0);
    filling = 1'b0;
    draining = 1'b0;
    edges(1);
`endif

    // Late second request.
    filling = 1'b1;
    edges(6);
    waiting = 1'b1;
    edges(1);
`ifdef CHAMBER_TIMER_FAULT_EN
    chk("late_fault_e6", int'(fault), 1);
    chk("late_sec_e6", int'(secLeft), 0);
`else
    chk("late_fault_e6", int'(fault), 0);
    chk("late_sec_e6", int'(secLeft), 2);
    edges(6);
    chk("late_fin_e12", int'(fillFinished), 1);
    chk("late_wait_e12", int'(waitFinished), 0);
`endif
    filling = 1'b0;
    waiting = 1'b0;
    edges(2);

    // Random request traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) filling = ~filling;
      if ($urandom_range(0, 39) == 0) draining = ~draining;
      if ($urandom_range(0, 39) == 0) waiting = ~waiting;
      nReset = ($urandom_range(0, 499) == 0);
      edges(1);
    end
    nReset = 1'b0;
    filling = 1'b0;
    draining = 1'b0;
    waiting = 1'b0;
    edges(3);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
